// File: rtl/oppm_decoder.sv
// rtl/oppm_decoder.sv - OPPM pulse-line receiver: preamble lock, symbol demodulation, packet strobe.
// Optional saturating error counter output enabled by defining OPPM_DEC_ERRCNT_EN.
module oppm_decoder #(
    parameter int N_MOD  = 2,
    parameter int L      = 4,
    parameter int N_PKT  = 8,
    parameter int PRE_CT = 3,
    parameter int TOL    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse,
    output logic [N_PKT-1:0] data,
    output logic             data_valid,
    output logic             data_err,
    output logic             locked
`ifdef OPPM_DEC_ERRCNT_EN
    ,
    output logic [7:0]       err_count
`endif
);
    localparam int P      = L * (2 ** N_MOD);
    localparam int SYM_CT = N_PKT / N_MOD;
    localparam int TW     = $clog2(P + L);
    localparam int CW     = $clog2(PRE_CT + 1);
    localparam int KW     = (SYM_CT > 1) ? $clog2(SYM_CT) : 1;

    localparam logic [0:0] HUNT = 1'b0;
    localparam logic [0:0] DATA = 1'b1;

    logic [0:0]       state;
    logic             pulse_q;
    logic [TW-1:0]    timer;
    logic [CW-1:0]    cnt;
    logic [KW-1:0]    k;
    logic             pre;
    logic             seen;
    logic [N_PKT-1:0] sr;

    logic             pulse_rise;
    logic             spacing_ok;
    logic [N_MOD-1:0] sym_d;
    logic [N_PKT-1:0] sr_next;

    always_comb begin
        pulse_rise = pulse & ~pulse_q;
        spacing_ok = (timer >= TW'(P - TOL)) && (timer <= TW'(P + TOL));
        // In a data window the timer is the offset from window start, so floor
        // division by L rounds the edge to the nearest slot.
        sym_d      = N_MOD'(timer / TW'(L));
        sr_next    = (sr << N_MOD) | N_PKT'(sym_d);
    end

    assign locked = (state == DATA);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            pulse_q    <= 1'b0;
            timer      <= '0;
            cnt        <= '0;
            k          <= '0;
            pre        <= 1'b0;
            seen       <= 1'b0;
            sr         <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            data_err   <= 1'b0;
        end else begin
            pulse_q    <= pulse;
            data_valid <= 1'b0;
            data_err   <= 1'b0;
            if (state == HUNT) begin
                if (pulse_rise)
                    timer <= TW'(1);
                else if (timer != '1)
                    timer <= timer + TW'(1);
                if (pulse_rise) begin
                    if (cnt != '0 && spacing_ok) begin
                        if (cnt == CW'(PRE_CT - 1)) begin
                            state <= DATA;
                            cnt   <= '0;
                            pre   <= 1'b1;
                            k     <= '0;
                            seen  <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else begin
                        cnt <= CW'(1);
                    end
                end else if (cnt != '0 && timer == TW'(P + TOL)) begin
                    cnt <= '0;
                end
            end else if (pre) begin
                // Dead time between the last preamble edge and the first window opening.
                if (timer == TW'(P - L / 2 - 1)) begin
                    timer <= '0;
                    pre   <= 1'b0;
                end else begin
                    timer <= timer + TW'(1);
                end
            end else if (pulse_rise && seen) begin
                data_err <= 1'b1;
                state    <= HUNT;
                cnt      <= '0;
            end else begin
                if (pulse_rise)
                    sr <= sr_next;
                if (pulse_rise && k == KW'(SYM_CT - 1)) begin
                    data       <= sr_next;
                    data_valid <= 1'b1;
                    state      <= HUNT;
                    cnt        <= '0;
                end else if (timer == TW'(P - 1)) begin
                    if (pulse_rise || seen) begin
                        k     <= k + KW'(1);
                        seen  <= 1'b0;
                        timer <= '0;
                    end else begin
                        data_err <= 1'b1;
                        state    <= HUNT;
                        cnt      <= '0;
                    end
                end else begin
                    timer <= timer + TW'(1);
                    if (pulse_rise)
                        seen <= 1'b1;
                end
            end
        end
    end

`ifdef OPPM_DEC_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            err_count <= '0;
        else if (data_err && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
`endif

endmodule
